// File: rtl/wb_master_adapter.sv
// Wishbone classic single-transfer master: takes one request on a valid/ready
// port, runs one CYC/STB cycle until ACK or timeout, returns a one-cycle response.
module wb_master_adapter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int GRANULARITY = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic                                req_we_i,
  input  logic [ADDR_WIDTH-1:0]               req_adr_i,
  input  logic [DATA_WIDTH-1:0]               req_dat_i,
  input  logic [DATA_WIDTH/GRANULARITY-1:0]   req_sel_i,
  output logic                                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]               rsp_dat_o,
  output logic                                rsp_err_o,
  output logic [ADDR_WIDTH-1:0]               adr_o,
  output logic [DATA_WIDTH-1:0]               dat_o,
  input  logic [DATA_WIDTH-1:0]               dat_i,
  output logic                                we_o,
  output logic [DATA_WIDTH/GRANULARITY-1:0]   sel_o,
  output logic                                stb_o,
  output logic                                cyc_o,
  input  logic                                ack_i
);
  // state   | meaning
  // ST_IDLE | ready for a request (req_ready_o = 1)
  // ST_BUS  | Wishbone cycle open, waiting for ACK or timeout
  // ST_RESP | one-cycle response pulse on rsp_valid_o

  localparam int SEL_WIDTH = DATA_WIDTH / GRANULARITY;
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
  localparam bit TMO_EN = (TIMEOUT > 0);

  if (GRANULARITY != 8 && GRANULARITY != 16 && GRANULARITY != 32) begin : g_bad_granularity
    $fatal(1, "wb_master_adapter: GRANULARITY must be 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]  tmr, tmr_nxt;
  logic                  tmo_hit;
  logic                  cyc_nxt, stb_nxt, we_nxt;
  logic [ADDR_WIDTH-1:0] adr_nxt;
  logic [DATA_WIDTH-1:0] dat_nxt;
  logic [SEL_WIDTH-1:0]  sel_nxt;
  logic                  rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_WIDTH-1:0] rsp_dat_nxt;

  // Down-counter loaded with TIMEOUT-1; terminal count at zero. ACK has priority.
  assign tmo_hit = TMO_EN && (tmr == '0) && !ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid_i) state_nxt = ST_BUS;
      ST_BUS:  if (ack_i || tmo_hit) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = (state == ST_IDLE);
    cyc_nxt       = cyc_o;
    stb_nxt       = stb_o;
    we_nxt        = we_o;
    adr_nxt       = adr_o;
    dat_nxt       = dat_o;
    sel_nxt       = sel_o;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = rsp_err_o;
    rsp_dat_nxt   = rsp_dat_o;
    tmr_nxt       = tmr;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          cyc_nxt = 1'b1;
          stb_nxt = 1'b1;
          we_nxt  = req_we_i;
          adr_nxt = req_adr_i;
          dat_nxt = req_dat_i;
          sel_nxt = req_sel_i;
          tmr_nxt = CNT_LOAD;
        end
      end
      ST_BUS: begin
        if (ack_i) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_dat_nxt   = we_o ? '0 : dat_i;
        end else if (tmo_hit) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_dat_nxt   = '0;
        end else if (tmr != '0) begin
          tmr_nxt = tmr - CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      sel_o       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      tmr         <= '0;
    end else begin
      cyc_o       <= cyc_nxt;
      stb_o       <= stb_nxt;
      we_o        <= we_nxt;
      adr_o       <= adr_nxt;
      dat_o       <= dat_nxt;
      sel_o       <= sel_nxt;
      rsp_valid_o <= rsp_valid_nxt;
      rsp_err_o   <= rsp_err_nxt;
      rsp_dat_o   <= rsp_dat_nxt;
      tmr         <= tmr_nxt;
    end
  end

endmodule
